register_serializer: RTL and testbench

- Parallel-to-serial transmitter. It reads an 8-bit word out of a holding register and drives it onto a single serial line as a framed bitstream.
- It is the drain end of the register path: a register captures a word in parallel, and this block emits the word one bit at a time.
- It pairs with a future serial-receive/deserializer block.

---
 rtl/register_serializer.sv | 160 ++++++++++++++++
 tb/tb_register_serializer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/register_serializer.sv
// Parallel-to-serial framed transmitter: START(0), WIDTH data bits, optional parity, STOP(1).
// Define SERIALIZER_PARITY_EN to insert an even-parity bit between DATA and STOP.
module register_serializer #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter bit MSB_FIRST    = 1'b0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] Data_in,
  input  logic             load,
  output logic             ready,
  output logic             busy,
  output logic             serial_out,
  output logic             done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

`ifdef SERIALIZER_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t           r_state, w_state_nx;
  logic [WIDTH-1:0] r_shift, w_shift_nx, w_shifted;
  logic [BW-1:0]    r_bit_cnt, w_bit_nx;
  logic [CW-1:0]    r_baud_cnt, w_baud_nx;
  logic             r_serial, r_ready, r_busy, r_done;
  logic             w_serial_nx, w_done_nx;
  logic             w_baud_last, w_cur_bit, w_next_bit;
`ifdef SERIALIZER_PARITY_EN
  logic             r_parity, w_parity_nx;
`endif

  assign w_baud_last = (r_baud_cnt == BAUD_MAX);
  assign w_shifted   = MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);
  assign w_cur_bit   = MSB_FIRST ? r_shift[WIDTH-1]   : r_shift[0];
  assign w_next_bit  = MSB_FIRST ? w_shifted[WIDTH-1] : w_shifted[0];

  // Outputs are registered from the next-state decode so they line up with the
  // state they describe, with no combinational path from the inputs.
  always_comb begin
    w_state_nx  = r_state;
    w_shift_nx  = r_shift;
    w_bit_nx    = r_bit_cnt;
    w_baud_nx   = r_baud_cnt;
    w_serial_nx = 1'b1;
    w_done_nx   = 1'b0;
`ifdef SERIALIZER_PARITY_EN
    w_parity_nx = r_parity;
`endif
    case (r_state)
      S_IDLE: begin
        if (load) begin
          w_state_nx  = S_START;
          w_shift_nx  = Data_in;
          w_bit_nx    = '0;
          w_baud_nx   = '0;
          w_serial_nx = 1'b0;
`ifdef SERIALIZER_PARITY_EN
          w_parity_nx = ^Data_in;
`endif
        end
      end
      S_START: begin
        w_serial_nx = 1'b0;
        if (w_baud_last) begin
          w_baud_nx   = '0;
          w_state_nx  = S_DATA;
          w_serial_nx = w_cur_bit;
        end else begin
          w_baud_nx = r_baud_cnt + 1'b1;
        end
      end
      S_DATA: begin
        w_serial_nx = w_cur_bit;
        if (w_baud_last) begin
          w_baud_nx = '0;
          if (r_bit_cnt == BIT_LAST) begin
            w_bit_nx = '0;
`ifdef SERIALIZER_PARITY_EN
            w_state_nx  = S_PARITY;
            w_serial_nx = r_parity;
`else
            w_state_nx  = S_STOP;
            w_serial_nx = 1'b1;
`endif
          end else begin
            w_shift_nx  = w_shifted;
            w_bit_nx    = r_bit_cnt + 1'b1;
            w_serial_nx = w_next_bit;
          end
        end else begin
          w_baud_nx = r_baud_cnt + 1'b1;
        end
      end
`ifdef SERIALIZER_PARITY_EN
      S_PARITY: begin
        w_serial_nx = r_parity;
        if (w_baud_last) begin
          w_baud_nx   = '0;
          w_state_nx  = S_STOP;
          w_serial_nx = 1'b1;
        end else begin
          w_baud_nx = r_baud_cnt + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (w_baud_last) begin
          w_baud_nx  = '0;
          w_state_nx = S_IDLE;
          w_done_nx  = 1'b1;
        end else begin
          w_baud_nx = r_baud_cnt + 1'b1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_baud_cnt <= '0;
      r_serial   <= 1'b1;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nx;
      r_shift    <= w_shift_nx;
      r_bit_cnt  <= w_bit_nx;
      r_baud_cnt <= w_baud_nx;
      r_serial   <= w_serial_nx;
      r_ready    <= (w_state_nx == S_IDLE);
      r_busy     <= (w_state_nx != S_IDLE);
      r_done     <= w_done_nx;
`ifdef SERIALIZER_PARITY_EN
      r_parity   <= w_parity_nx;
`endif
    end
  end

  assign serial_out = r_serial;
  assign ready      = r_ready;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_register_serializer.sv
// Scoreboard bench: expected per-cycle {serial,ready,busy,done} tuples are queued at
// stimulus time; a negedge monitor pops one whenever a DUT is busy or pulses done.
module tb_register_serializer;
  logic       clock, reset_n;
  logic [2:0] ld, rdy, bsy, so, dn;
  logic [7:0] din [3];
  logic [3:0] q0[$], q1[$], q2[$];
  int n_tests = 0, n_fail = 0;

  // u0: LSB first, 4 clk/bit; u1: MSB first, 4 clk/bit; u2: LSB first, 1 clk/bit
  register_serializer #(.WIDTH(8), .CLKS_PER_BIT(4), .MSB_FIRST(1'b0)) u0 (
    .clock(clock), .reset_n(reset_n), .Data_in(din[0]), .load(ld[0]),
    .ready(rdy[0]), .busy(bsy[0]), .serial_out(so[0]), .done(dn[0]));
  register_serializer #(.WIDTH(8), .CLKS_PER_BIT(4), .MSB_FIRST(1'b1)) u1 (
    .clock(clock), .reset_n(reset_n), .Data_in(din[1]), .load(ld[1]),
    .ready(rdy[1]), .busy(bsy[1]), .serial_out(so[1]), .done(dn[1]));
  register_serializer #(.WIDTH(8), .CLKS_PER_BIT(1), .MSB_FIRST(1'b0)) u2 (
    .clock(clock), .reset_n(reset_n), .Data_in(din[2]), .load(ld[2]),
    .ready(rdy[2]), .busy(bsy[2]), .serial_out(so[2]), .done(dn[2]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b ({serial,ready,busy,done}) t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic qpush(input int id, input logic [3:0] v);
    case (id)
      0: q0.push_back(v);
      1: q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  function automatic int qsize(input int id);
    case (id)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [3:0] qpop(input int id);
    case (id)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  // seq holds the data bits in transmit order, first-sent bit in seq[7]
  task automatic push_frame(input int id, input int cpb, input logic [7:0] seq, input logic par);
    for (int c = 0; c < cpb; c++) qpush(id, 4'b0010);
    for (int b = 7; b >= 0; b--)
      for (int c = 0; c < cpb; c++) qpush(id, {seq[b], 3'b010});
`ifdef SERIALIZER_PARITY_EN
    for (int c = 0; c < cpb; c++) qpush(id, {par, 3'b010});
`else
    if (par === 1'bx) $display("note: parity value unknown");
`endif
    for (int c = 0; c < cpb; c++) qpush(id, 4'b1010);
    qpush(id, 4'b1101);
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      for (int i = 0; i < 3; i++) begin
        if (bsy[i] || dn[i]) begin
          if (qsize(i) == 0) begin
            n_tests++; n_fail++;
            $display("FAIL mon%0d unexpected output: got %b want idle t=%0t",
                     i, {so[i], rdy[i], bsy[i], dn[i]}, $time);
          end else begin
            chk($sformatf("mon%0d", i), {so[i], rdy[i], bsy[i], dn[i]}, qpop(i));
          end
        end
      end
    end
  end

  task automatic send(input int id, input logic [7:0] d);
    @(posedge clock); #1;
    din[id] = d; ld[id] = 1'b1;
    @(posedge clock); #1;
    ld[id] = 1'b0;
  endtask

  task automatic drain(input string nm, input int budget);
    int k = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && k < budget) begin
      @(posedge clock); k++;
    end
    n_tests++;
    if ((q0.size() + q1.size() + q2.size()) != 0) begin
      n_fail++;
      $display("FAIL %s drain timeout: %0d/%0d/%0d entries left, want 0", nm,
               q0.size(), q1.size(), q2.size());
      q0.delete(); q1.delete(); q2.delete();
    end
    repeat (3) @(posedge clock);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    reset_n = 1'b0; ld = '0;
    for (int i = 0; i < 3; i++) din[i] = '0;
    repeat (3) @(negedge clock);
    for (int i = 0; i < 3; i++) chk($sformatf("reset%0d", i), {so[i], rdy[i], bsy[i], dn[i]}, 4'b1100);
    @(posedge clock); #1 reset_n = 1'b1;
    repeat (10) begin
      @(negedge clock);
      for (int i = 0; i < 3; i++) chk($sformatf("idle%0d", i), {so[i], rdy[i], bsy[i], dn[i]}, 4'b1100);
    end

    // A5 LSB first: 1,0,1,0,0,1,0,1
    push_frame(0, 4, 8'b10100101, 1'b0); send(0, 8'hA5); drain("a5_lsb", 200);
    // 81 MSB first: 1,0,0,0,0,0,0,1
    push_frame(1, 4, 8'b10000001, 1'b0); send(1, 8'h81); drain("81_msb", 200);
    // C3 at one clock per bit: 1,1,0,0,0,0,1,1
    push_frame(2, 1, 8'b11000011, 1'b0); send(2, 8'hC3); drain("c3_cpb1", 200);
    // 07 LSB first: 1,1,1,0,0,0,0,0, odd ones count so parity 1
    push_frame(0, 4, 8'b11100000, 1'b1); send(0, 8'h07); drain("07_par", 200);

    // load held high; Data_in changes to 3C mid-frame
    push_frame(0, 4, 8'b10100101, 1'b0);
    push_frame(0, 4, 8'b00111100, 1'b0);
    @(posedge clock); #1 din[0] = 8'hA5; ld[0] = 1'b1;
    repeat (20) @(posedge clock);
    #1 din[0] = 8'h3C;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clock);
      seen = dn[0];
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL back2back done: got no done pulse within 200 cycles, want 1");
    end
    repeat (5) @(posedge clock);
    #1 ld[0] = 1'b0;
    drain("back2back", 200);

    // async reset in DATA bit 3 of A5 (bit 3 = 0), then a clean 5A frame
    push_frame(0, 4, 8'b10100101, 1'b0); send(0, 8'hA5);
    repeat (16) @(posedge clock);
    #2 reset_n = 1'b0;
    q0.delete();
    #1 chk("async_rst", {so[0], rdy[0], bsy[0], dn[0]}, 4'b1100);
    @(posedge clock); #1 reset_n = 1'b1;
    repeat (5) @(posedge clock);
    // 5A LSB first: 0,1,0,1,1,0,1,0
    push_frame(0, 4, 8'b01011010, 1'b0); send(0, 8'h5A); drain("5a_after_rst", 200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
